imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe_if.sv | 59 +++++
 rtl/imm_gen_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle between the fetch/IR side, imm_gen_pipe and the operand mux
//
// Parameters:
//   XLEN  - immediate width (32 or 64)
//   TAG_W - sideband tag width (typically the PC)
//
// Signals:
//   in_valid/in_ready/in_inst/in_tag          - instruction input handshake
//   out_valid/out_ready/out_imm/out_fmt/
//   out_illegal/out_tag                       - decoded immediate output handshake
//
// Modports:
//   master - the surrounding pipeline (drives instructions, consumes immediates)
//   slave  - the immediate generator stage

interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid,
        output in_inst,
        output in_tag,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_fmt,
        input  out_illegal,
        input  out_tag,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_tag,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_fmt,
        output out_illegal,
        output out_tag,
        input  out_ready
    );

endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered, flow-controlled RISC-V immediate generator with 2-entry skid buffer
//
// Parameters:
//   XLEN    - immediate width, 32 or 64; signed immediates are sign-extended to XLEN
//   SHAMT_W - shift-amount width, 5 for RV32, 6 for RV64
//   TAG_W   - sideband tag width, passed through unmodified
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset; zeroes every output and empties the buffer
//   flush - synchronous drop of all buffered entries (an entry accepted in the same cycle is dropped too)
//   bus   - imm_gen_pipe_if.slave: in_valid/in_ready/in_inst/in_tag and
//           out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag
//   illegal_cnt - (only with IMM_ILLEGAL_CNT_EN defined) saturating count of accepted illegal opcodes
//
// Optional feature macro: IMM_ILLEGAL_CNT_EN
//
// out_fmt encoding: 0 none(R), 1 I, 2 S, 3 B, 4 U, 5 J, 6 I-shift, 7 illegal.

module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    imm_gen_pipe_if.slave     bus
`ifdef IMM_ILLEGAL_CNT_EN
    ,
    output logic [15:0]       illegal_cnt
`endif
);

    // Format codes
    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_ISHFT = 3'd6;
    localparam logic [2:0] FMT_ILL   = 3'd7;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     imm32;
    logic            use_shamt;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // imm32 holds the 32-bit sign-extended form of every signed immediate;
    // widening to XLEN is a single signed cast below, so RV64 needs no extra cases.
    always_comb begin
        imm32     = 32'd0;
        use_shamt = 1'b0;
        dec_fmt   = FMT_ILL;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            OP_IMM: begin
                // slli/srli/srai carry a shift amount, not a signed immediate
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt   = FMT_ISHFT;
                    use_shamt = 1'b1;
                end else begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                imm32   = {inst[31:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_REG: begin
                dec_fmt = FMT_R;
            end
            default: begin
                // Unknown opcode: immediate stays zero so nothing stale leaks out
                dec_fmt = FMT_ILL;
            end
        endcase
    end

    assign dec_imm     = use_shamt ? XLEN'(inst[20 +: SHAMT_W]) : XLEN'($signed(imm32));
    assign dec_illegal = (dec_fmt == FMT_ILL);

    // ------------------------------------------------------------------
    // Two-slot buffer: slot A drives the outputs, slot B is the skid entry
    // ------------------------------------------------------------------
    logic             a_valid;
    logic [XLEN-1:0]  a_imm;
    logic [2:0]       a_fmt;
    logic             a_illegal;
    logic [TAG_W-1:0] a_tag;

    logic             b_valid;
    logic [XLEN-1:0]  b_imm;
    logic [2:0]       b_fmt;
    logic             b_illegal;
    logic [TAG_W-1:0] b_tag;

    logic             accept;
    logic             pop;
    logic             a_free;

    // in_ready comes straight from the B valid flop, so it never depends
    // combinationally on out_ready.
    assign bus.in_ready = !b_valid;
    assign accept       = bus.in_valid && !b_valid;
    assign pop          = a_valid && bus.out_ready;
    // A can be (re)loaded when it is empty or its current entry leaves this cycle
    assign a_free       = !a_valid || pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_imm     <= '0;
            a_fmt     <= 3'd0;
            a_illegal <= 1'b0;
            a_tag     <= '0;
            b_valid   <= 1'b0;
            b_imm     <= '0;
            b_fmt     <= 3'd0;
            b_illegal <= 1'b0;
            b_tag     <= '0;
        end else if (flush) begin
            // Payloads are left alone; only validity matters after a flush
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else if (a_free) begin
            if (b_valid) begin
                // B is older than anything arriving now (and in_ready is low), so it goes first
                a_valid   <= 1'b1;
                a_imm     <= b_imm;
                a_fmt     <= b_fmt;
                a_illegal <= b_illegal;
                a_tag     <= b_tag;
                b_valid   <= 1'b0;
            end else if (accept) begin
                a_valid   <= 1'b1;
                a_imm     <= dec_imm;
                a_fmt     <= dec_fmt;
                a_illegal <= dec_illegal;
                a_tag     <= bus.in_tag;
            end else begin
                a_valid <= 1'b0;
            end
        end else if (accept) begin
            // A is held by backpressure; park the new entry in B
            b_valid   <= 1'b1;
            b_imm     <= dec_imm;
            b_fmt     <= dec_fmt;
            b_illegal <= dec_illegal;
            b_tag     <= bus.in_tag;
        end
    end

    assign bus.out_valid   = a_valid;
    assign bus.out_imm     = a_imm;
    assign bus.out_fmt     = a_fmt;
    assign bus.out_illegal = a_illegal;
    assign bus.out_tag     = a_tag;

`ifdef IMM_ILLEGAL_CNT_EN
    // ------------------------------------------------------------------
    // Saturating count of accepted illegal opcodes (flushed cycles excluded)
    // ------------------------------------------------------------------
    logic [15:0] ill_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ill_cnt_q <= 16'd0;
        end else if (!flush && accept && dec_illegal && (ill_cnt_q != 16'hFFFF)) begin
            ill_cnt_q <= ill_cnt_q + 16'd1;
        end
    end

    assign illegal_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (RV32 and RV64 instances side by side)

module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [31:0] in_tag;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_inst   = in_inst;
    assign b32.in_tag    = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_inst   = in_inst;
    assign b64.in_tag    = in_tag;
    assign b64.out_ready = out_ready;

`ifdef IMM_ILLEGAL_CNT_EN
    logic [15:0] cnt32;
    logic [15:0] cnt64;
`endif

    imm_gen_pipe #(.XLEN(32), .SHAMT_W(5), .TAG_W(32)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b32)
`ifdef IMM_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (cnt32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .SHAMT_W(6), .TAG_W(32)) u_dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b64)
`ifdef IMM_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (cnt64)
`endif
    );

    // Reference model: a FIFO of expected entries, at most two deep
    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        int          fmt;
        logic [31:0] tag;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   ref_ill_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned v, input int bits);
        if (((v >> (bits - 1)) & 64'd1) != 64'd0)
            return longint'(v) - (longint'(1) << bits);
        return longint'(v);
    endfunction

    // Immediate reconstruction from field positions with plain arithmetic
    function automatic void ref_dec(input logic [31:0] inst, input int xlen,
                                    output logic [63:0] imm, output int fmt);
        longint unsigned w;
        longint          v;
        int              op;
        int              f3;
        int              sh;
        w  = 64'(inst);
        op = int'(w & 64'h7F);
        f3 = int'((w >> 12) & 64'h7);
        sh = (xlen == 64) ? 6 : 5;
        v  = 0;
        case (op)
            'h03, 'h67: begin fmt = 1; v = sx((w >> 20) & 64'hFFF, 12); end
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    fmt = 6;
                    v   = longint'((w >> 20) & ((64'd1 << sh) - 64'd1));
                end else begin
                    fmt = 1;
                    v   = sx((w >> 20) & 64'hFFF, 12);
                end
            end
            'h23: begin fmt = 2; v = sx((((w >> 25) & 64'h7F) << 5) | ((w >> 7) & 64'h1F), 12); end
            'h63: begin
                fmt = 3;
                v = sx((((w >> 31) & 64'h1) << 12) | (((w >> 7) & 64'h1) << 11) |
                       (((w >> 25) & 64'h3F) << 5) | (((w >> 8) & 64'hF) << 1), 13);
            end
            'h37, 'h17: begin fmt = 4; v = sx(w & 64'hFFFF_F000, 32); end
            'h6F: begin
                fmt = 5;
                v = sx((((w >> 31) & 64'h1) << 20) | (((w >> 12) & 64'hFF) << 12) |
                       (((w >> 20) & 64'h1) << 11) | (((w >> 21) & 64'h3FF) << 1), 21);
            end
            'h33: begin fmt = 0; v = 0; end
            default: begin fmt = 7; v = 0; end
        endcase
        imm = (xlen == 32) ? ($unsigned(v) & 64'hFFFF_FFFF) : $unsigned(v);
    endfunction

    task automatic check_outputs();
        chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
        chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
        chk("in_ready32",  64'(b32.in_ready),  64'(q.size() < 2));
        chk("in_ready64",  64'(b64.in_ready),  64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("imm32",  64'(b32.out_imm), q[0].imm32);
            chk("imm64",  b64.out_imm,      q[0].imm64);
            chk("fmt32",  64'(b32.out_fmt), 64'(q[0].fmt));
            chk("fmt64",  64'(b64.out_fmt), 64'(q[0].fmt));
            chk("ill32",  64'(b32.out_illegal), 64'(q[0].fmt == 7));
            chk("ill64",  64'(b64.out_illegal), 64'(q[0].fmt == 7));
            chk("tag32",  64'(b32.out_tag), 64'(q[0].tag));
            chk("tag64",  64'(b64.out_tag), 64'(q[0].tag));
        end
`ifdef IMM_ILLEGAL_CNT_EN
        chk("ill_cnt32", 64'(cnt32), 64'(ref_ill_cnt));
        chk("ill_cnt64", 64'(cnt64), 64'(ref_ill_cnt));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the falling edge
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                        input logic ordy, input logic fl, input logic rs);
        ent_t e;
        int   n;
        bit   acc;
        in_valid  = v;
        in_inst   = inst;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            ref_ill_cnt = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            n   = q.size();
            acc = v && (n < 2);
            if (n > 0 && ordy)
                void'(q.pop_front());
            if (acc) begin
                ref_dec(inst, 32, e.imm32, e.fmt);
                ref_dec(inst, 64, e.imm64, e.fmt);
                e.tag = tag;
                q.push_back(e);
                if (e.fmt == 7 && ref_ill_cnt < 65535)
                    ref_ill_cnt++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 64'(b32.out_valid),   64'd0);
        chk({tag, "_imm32"}, 64'(b32.out_imm),     64'd0);
        chk({tag, "_imm64"}, b64.out_imm,          64'd0);
        chk({tag, "_fmt"},   64'(b32.out_fmt),     64'd0);
        chk({tag, "_ill"},   64'(b32.out_illegal), 64'd0);
        chk({tag, "_tag"},   64'(b32.out_tag),     64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        logic [6:0]  ops [10];
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        // Reset
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_zero_outputs("reset");
        idle(1'b1);
        chk("reset_in_ready", 64'(b32.in_ready), 64'd1);

        // Basic decode, back to back with the consumer always ready
        step(1'b1, 32'hFFF00093, 32'h0000_1000, 1'b1, 1'b0, 1'b0);
        chk("addi_imm", 64'(b32.out_imm), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(b32.out_fmt), 64'd1);
        chk("addi_tag", 64'(b32.out_tag), 64'h1000);
        step(1'b1, 32'h4030D093, 32'h0000_1004, 1'b1, 1'b0, 1'b0);
        chk("srai_imm", 64'(b32.out_imm), 64'd3);
        chk("srai_fmt", 64'(b32.out_fmt), 64'd6);
        step(1'b1, 32'hFE112E23, 32'h0000_1008, 1'b1, 1'b0, 1'b0);
        chk("sw_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
        chk("sw_fmt", 64'(b32.out_fmt), 64'd2);
        step(1'b1, 32'hFF9FF06F, 32'h0000_100C, 1'b1, 1'b0, 1'b0);
        chk("jal_imm32", 64'(b32.out_imm), 64'hFFFF_FFF8);
        chk("jal_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("jal_fmt", 64'(b32.out_fmt), 64'd5);
        step(1'b1, 32'h0000007F, 32'h0000_1010, 1'b1, 1'b0, 1'b0);
        chk("illegal_flag", 64'(b32.out_illegal), 64'd1);
        chk("illegal_fmt", 64'(b32.out_fmt), 64'd7);
        chk("illegal_imm", 64'(b32.out_imm), 64'd0);
`ifdef IMM_ILLEGAL_CNT_EN
        chk("illegal_cnt_one", 64'(cnt32), 64'd1);
`endif
        idle(1'b1);

        // Backpressure: three pushes, only two fit
        step(1'b1, 32'h00500113, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00A00193, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00F00213, 32'h0000_2008, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_head_tag", 64'(b32.out_tag), 64'h2000);
        step(1'b1, 32'h01400293, 32'h0000_200C, 1'b0, 1'b0, 1'b0);
        chk("bp_head_held", 64'(b32.out_imm), 64'd5);
        idle(1'b1);
        chk("bp_second", 64'(b32.out_imm), 64'd10);
        idle(1'b1);
        idle(1'b1);

        // Flush with both slots full and a simultaneous push
        step(1'b1, 32'h00100313, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200393, 32'h0000_3004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00300413, 32'h0000_3008, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_in_ready", 64'(b32.in_ready), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Reset in the middle of traffic
        step(1'b1, 32'hFFF00093, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFE112E23, 32'h0000_4004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFF9FF06F, 32'h0000_4008, 1'b0, 1'b1, 1'b1);
        check_zero_outputs("midrst");
        idle(1'b1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom();
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom()) : ops[$urandom_range(0, 8)];
            step(1'($urandom_range(0, 3) != 0), {r[31:7], op}, $urandom(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
